// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared across the pipeline stages
package pipe_pkg;
  localparam logic [31:0] BUBBLE_INST = 32'hff00_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {FETCH = 2'd0, KILL = 2'd1, HOLD = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding an instruction word and its pc+4
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  input  logic [31:0] dpc4,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);
  // clear wins so a redirect always empties the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst <= '0;
      pc4 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst <= din;
      pc4 <= dpc4;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and single-outstanding imem requester; FETCH_SKID_EN buffers responses arriving during stall
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE = BUBBLE_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        inst_valid
);
  fetch_state_t state, state_d;
  logic [31:0] pc, pc_d, fetch_addr, addr_d, inst_d, pc4_d, nxt;
  logic valid_d;
`ifdef FETCH_SKID_EN
  logic load, clear, buf_valid;
  logic [31:0] buf_inst, buf_pc4;
  fetch_skid_buf u_skid (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(clear),
    .din(imem_rdata), .dpc4(nxt),
    .valid(buf_valid), .inst(buf_inst), .pc4(buf_pc4)
  );
`endif
  assign nxt = fetch_addr + PC_STEP;
  assign imem_req = state != HOLD;
  assign imem_addr = fetch_addr;
  // next-state: redirect beats everything, KILL drains the orphaned request, stall freezes outputs
  always_comb begin
    state_d = state;
    pc_d = pc;
    addr_d = fetch_addr;
    inst_d = inst_out;
    pc4_d = pc4_out;
    valid_d = inst_valid;
`ifdef FETCH_SKID_EN
    load = 1'b0;
    clear = 1'b0;
`endif
    if (redirect) begin
      inst_d = BUBBLE;
      valid_d = 1'b0;
      pc_d = redirect_pc;
`ifdef FETCH_SKID_EN
      clear = 1'b1;
`endif
      if (state != HOLD && !imem_rvalid) begin
        state_d = KILL;
      end else begin
        state_d = FETCH;
        addr_d = redirect_pc;
      end
    end else if (state == KILL) begin
      if (imem_rvalid) begin
        state_d = FETCH;
        addr_d = pc;
      end
`ifdef FETCH_SKID_EN
    end else if (state == HOLD) begin
      if (!stall) begin
        inst_d = buf_valid ? buf_inst : BUBBLE;
        pc4_d = buf_pc4;
        valid_d = buf_valid;
        addr_d = nxt;
        pc_d = nxt;
        clear = 1'b1;
        state_d = FETCH;
      end
    end else if (stall) begin
      if (imem_rvalid) begin
        load = 1'b1;
        state_d = HOLD;
      end
`else
    end else if (stall) begin
      state_d = FETCH;
`endif
    end else if (imem_rvalid) begin
      inst_d = imem_rdata;
      pc4_d = nxt;
      valid_d = 1'b1;
      addr_d = nxt;
      pc_d = nxt;
    end else begin
      inst_d = BUBBLE;
      valid_d = 1'b0;
    end
  end
  // state, address and IF/ID output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      fetch_addr <= RESET_PC;
      inst_out <= BUBBLE;
      pc4_out <= '0;
      inst_valid <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      fetch_addr <= addr_d;
      inst_out <= inst_d;
      pc4_out <= pc4_d;
      inst_valid <= valid_d;
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU. Owns the program counter, issues one instruction-memory request at a time, and hands `inst_out`/`pc4_out` directly to the IF/ID pipeline register. Honours the ID-stage hazard stall and the EX/MEM branch/jump redirect. Inserts the pipeline bubble pattern whenever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `BUBBLE`, 32'hff00_0000, instruction word emitted for bubbles/flushes
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold IF outputs and PC
- `redirect`  in  1  taken branch/jump from EX/MEM; flush and refetch
- `redirect_pc`  in  32  target PC, sampled when `redirect`=1
- `imem_req`  out  1  request valid; held until `imem_rvalid`
- `imem_addr`  out  32  request address; stable while `imem_req`=1
- `imem_rvalid`  in  1  completes the outstanding request; may be high in the cycle `imem_req` first rises
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `inst_out`  out  32  instruction to IF/ID
- `pc4_out`  out  32  address of `inst_out` + 4
- `inst_valid`  out  1  `inst_out` is a real instruction, not `BUBBLE`

## Operation
- Registers: `pc` (next address to fetch), `fetch_addr` (drives `imem_addr`), state, outputs.
- States: FETCH (request outstanding), KILL (outstanding request orphaned by redirect), HOLD (instruction buffered during stall; `FETCH_SKID_EN` only).
- `imem_req` = 1 in FETCH and KILL, 0 in HOLD.
- FETCH, `imem_rvalid`=1, no stall/redirect: `inst_out`<=`imem_rdata`, `pc4_out`<=`fetch_addr`+4, `inst_valid`<=1, `fetch_addr`<=`fetch_addr`+4; stay FETCH.
- FETCH, `imem_rvalid`=0, no stall: `inst_out`<=`BUBBLE`, `inst_valid`<=0.
- `stall`=1: `inst_out`, `pc4_out`, `inst_valid` hold. A response arriving during stall is handled per Configuration.
- `redirect`=1 (highest priority, any state, overrides `stall`): next cycle `inst_out`=`BUBBLE`, `inst_valid`=0; `pc`,`fetch_addr` target `redirect_pc`. If a request is outstanding and `imem_rvalid`=0 -> KILL, else -> FETCH at `redirect_pc`.
- KILL: keep old address until `imem_rvalid`, discard data, then FETCH at stored redirect target. A second redirect in KILL overwrites the target.
- PC arithmetic modulo 2^32; 32'hffff_fffc + 4 wraps to 0. Low two address bits passed through unchecked.

## Timing
- Reset: `pc`=`fetch_addr`=`RESET_PC`, state FETCH, `inst_out`=`BUBBLE`, `pc4_out`=0, `inst_valid`=0; `imem_req`=1 after reset release.
- Latency: response accepted at edge N -> `inst_out` valid after edge N; next address presented in the same cycle.
- Zero-wait memory: one instruction per cycle.
- Reset during an outstanding request abandons it; the memory must tolerate a dropped `imem_req`.

## Configuration
- `FETCH_SKID_EN` defined: response during `stall` is captured in a one-entry buffer, state -> HOLD, `imem_req`=0; on `stall` falling the buffered word is issued to outputs, `fetch_addr` advances, -> FETCH. Redirect in HOLD empties the buffer.
- Undefined: response during `stall` is discarded; `fetch_addr` does not advance; the same address is re-requested after `stall` drops (replay). No HOLD state.

## Structure
- Shared package `pipe_pkg`: `BUBBLE_INST` (32'hff00_0000), `PC_STEP` (4), `fetch_state_t` enum {FETCH, KILL, HOLD}.
- Sub-module `fetch_skid_buf` (one-entry data+pc4 buffer with valid), instantiated only under `FETCH_SKID_EN`.

## Test plan
- Reset, zero-wait memory returning addr as data -> `inst_out` 0,4,8 on consecutive cycles, `pc4_out` 4,8,12, `inst_valid`=1.
- 3-cycle memory latency -> two `BUBBLE` cycles (`inst_valid`=0) between instructions; `imem_addr` stable while `imem_req`=1.
- `redirect`=1, `redirect_pc`=0x100 while request to 0x08 outstanding -> state KILL, 0x08 data dropped, next `imem_addr`=0x100, `inst_out`=`BUBBLE` meanwhile.
- `stall` 2 cycles with response at 0x0C -> outputs frozen; with `FETCH_SKID_EN` 0x0C issued on release with no refetch; without, 0x0C re-requested.
- `stall` and `redirect` same cycle, `redirect_pc`=0x40 -> redirect wins, bubble emitted, fetch 0x40.
- Start at `RESET_PC`=32'hffff_fffc -> second fetch address 0x0000_0000, `pc4_out`=0.
